// File: rtl/bscalc_pkg.sv
// Shared Black-Scholes datapath definitions: Q16.16 constants and the
// exponential-sharing controller state encoding.
package bscalc_pkg;

    // Q16.16 constants
    localparam logic [31:0] ONE           = 32'h0001_0000;
    localparam logic [31:0] X_MAX_DEFAULT = 32'h0008_0000;

    // Controller states; BYPASS is only reachable when clamping is built in
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        WAIT_CLR  = 3'd3,
        BYPASS    = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/exp_share_ctrl_if.sv
// Bus between the sharing controller and the e^(-x) unit.
// master = controller side (drives reset/start/operand), slave = unit side.
interface exp_share_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             exp_reset;
    logic             exp_start;
    logic [WIDTH-1:0] exp_x;
    logic [WIDTH-1:0] exp_y;
    logic             exp_done;

    modport master (
        output exp_reset,
        output exp_start,
        output exp_x,
        input  exp_y,
        input  exp_done
    );

    modport slave (
        input  exp_reset,
        input  exp_start,
        input  exp_x,
        output exp_y,
        output exp_done
    );
endinterface

// File: rtl/exp_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: picks the first active request at or after ptr,
// wrapping circularly. Purely combinational; the pointer lives in the caller.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  idx,
    output logic             any_req
);

    // Scan requesters starting at ptr; first hit wins
    always_comb begin
        int cand;
        gnt     = '0;
        idx     = '0;
        any_req = 1'b0;
        cand    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = (int'(ptr) + k) % N_REQ;
            if (!any_req && req[cand]) begin
                any_req   = 1'b1;
                idx       = ID_W'(cand);
                gnt[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exp_share_ctrl.sv
// Time-shares one e^(-x) unit (Q16.16, start/done handshake) among N_REQ
// requesters. Round-robin grant, operand latch, start pulse, result capture.
// The unit's reset is owned here so both sides always restart together.
// Optional macro EXP_CLAMP_EN: operands >= X_MAX return 0 and negative
// operands return 1.0 directly through a BYPASS state without using the unit.
module exp_share_ctrl
    import bscalc_pkg::*;
#(
    parameter int               WIDTH = 32,
    parameter int               N_REQ = 4,
    parameter int               ID_W  = 2,
    parameter logic [WIDTH-1:0] X_MAX = WIDTH'(X_MAX_DEFAULT)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ*WIDTH-1:0]  req_x,
    output logic [N_REQ-1:0]        gnt,
    output logic                    rsp_valid,
    output logic [ID_W-1:0]         rsp_id,
    output logic [WIDTH-1:0]        rsp_y,
    output logic                    busy,
    exp_share_ctrl_if.master        exp_bus
);

    // Elaboration-time parameter sanity checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_n_req
        $error("exp_share_ctrl: N_REQ must be in 2..8");
    end
    if (ID_W != $clog2(N_REQ)) begin : g_bad_id_w
        $error("exp_share_ctrl: ID_W must equal clog2(N_REQ)");
    end
    if (X_MAX[WIDTH-1]) begin : g_bad_x_max
        $error("exp_share_ctrl: X_MAX must be a positive Q16.16 value");
    end

    ctrl_state_e        state_q,     state_d;
    logic [ID_W-1:0]    rr_ptr_q,    rr_ptr_d;
    logic [ID_W-1:0]    id_q,        id_d;
    logic [WIDTH-1:0]   exp_x_q,     exp_x_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q,    rsp_id_d;
    logic [WIDTH-1:0]   rsp_y_q,     rsp_y_d;
    logic               exp_reset_q, exp_reset_d;
    logic               exp_start;

    logic [N_REQ-1:0]   arb_gnt;
    logic [ID_W-1:0]    arb_idx;
    logic               arb_any;
    logic [WIDTH-1:0]   sel_x;
    logic               take;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr_q),
        .gnt     (arb_gnt),
        .idx     (arb_idx),
        .any_req (arb_any)
    );

    // Operand of the current arbitration winner
    assign sel_x = req_x[int'(arb_idx)*WIDTH +: WIDTH];

    // A grant is taken only in IDLE and never while reset is asserted
    assign take = (state_q == IDLE) && arb_any && reset_n;
    assign gnt  = take ? arb_gnt : '0;

`ifdef EXP_CLAMP_EN
    logic clamp_hi;
    logic clamp_lo;

    // Saturation classes: large x underflows to 0, negative x is capped at 1.0
    assign clamp_lo = sel_x[WIDTH-1];
    assign clamp_hi = ($signed(sel_x) >= $signed(X_MAX));
`endif

    // The unit's reset follows our own reset, one cycle later
    assign exp_reset_d = ~reset_n;

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            exp_x_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_y_q     <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            exp_x_q     <= exp_x_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_y_q     <= rsp_y_d;
        end
        exp_reset_q <= exp_reset_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ISSUE;
`ifdef EXP_CLAMP_EN
                    if (clamp_hi || clamp_lo) begin
                        state_d = BYPASS;
                    end
`endif
                end
            end
            ISSUE:     state_d = WAIT_DONE;
            WAIT_DONE: if (exp_bus.exp_done)  state_d = WAIT_CLR;
            // Wait out the second done cycle so the next start is a clean edge
            WAIT_CLR:  if (!exp_bus.exp_done) state_d = IDLE;
            BYPASS:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Grant bookkeeping and result capture
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        exp_x_d     = exp_x_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_y_d     = rsp_y_q;
        if (take) begin
            exp_x_d  = sel_x;
            id_d     = arb_idx;
            rr_ptr_d = (int'(arb_idx) == N_REQ - 1) ? '0 : arb_idx + 1'b1;
`ifdef EXP_CLAMP_EN
            if (clamp_hi || clamp_lo) begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = arb_idx;
                rsp_y_d     = clamp_hi ? '0 : WIDTH'(ONE);
            end
`endif
        end
        if (state_q == WAIT_DONE && exp_bus.exp_done) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = id_q;
            rsp_y_d     = exp_bus.exp_y;
        end
    end

    // Moore outputs decoded from state
    always_comb begin
        exp_start = (state_q == ISSUE);
        busy      = (state_q != IDLE);
    end

    assign rsp_valid         = rsp_valid_q;
    assign rsp_id            = rsp_id_q;
    assign rsp_y             = rsp_y_q;
    assign exp_bus.exp_reset = exp_reset_q;
    assign exp_bus.exp_start = exp_start;
    assign exp_bus.exp_x     = exp_x_q;

endmodule

// File: tb/tb_exp_share_ctrl.sv
// Directed bench for exp_share_ctrl with a behavioural e^(-x) unit model
// (done raised 10 cycles after the start cycle, held for 2 cycles).
module tb_exp_share_ctrl;
    import bscalc_pkg::*;

    localparam int WIDTH = 32;
    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic                   clk = 1'b0;
    logic                   reset_n = 1'b0;
    logic [N_REQ-1:0]       req = '0;
    logic [N_REQ*WIDTH-1:0] req_x = '0;
    logic [N_REQ-1:0]       gnt;
    logic                   rsp_valid;
    logic [ID_W-1:0]        rsp_id;
    logic [WIDTH-1:0]       rsp_y;
    logic                   busy;

    exp_share_ctrl_if #(.WIDTH(WIDTH)) exp_bus ();

    exp_share_ctrl #(
        .WIDTH (WIDTH),
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .req_x     (req_x),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy),
        .exp_bus   (exp_bus)
    );

    always #5 clk = ~clk;

    // Hand-computed e^(-x) values in Q16.16 for the operands used here
    function automatic logic [31:0] unit_y(input logic [31:0] x);
        case (x)
            32'h0001_0000: return 32'h0000_5E2D;  // e^-1
            32'h0002_0000: return 32'h0000_22A5;  // e^-2
            32'h0003_0000: return 32'h0000_0CBF;  // e^-3
            32'h0004_0000: return 32'h0000_04B0;  // e^-4
            default:       return 32'hDEAD_BEEF;  // marker: passed through untouched
        endcase
    endfunction

    // Behavioural unit: t counts cycles since the start cycle
    int          t_u = 0;
    logic [31:0] y_u = '0;
    always @(posedge clk) begin
        if (exp_bus.exp_reset) begin
            t_u <= 0;
        end else if (exp_bus.exp_start) begin
            t_u <= 1;
            y_u <= unit_y(exp_bus.exp_x);
        end else if (t_u != 0) begin
            t_u <= (t_u == 12) ? 0 : t_u + 1;
        end
    end
    assign exp_bus.exp_done = (t_u == 10) || (t_u == 11);
    assign exp_bus.exp_y    = y_u;

    // Event monitors
    int cyc = 0, n_rsp = 0, n_rsp2 = 0, n_gnt2 = 0, n_start = 0, n_bad_start = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (rsp_valid) n_rsp <= n_rsp + 1;
        if (rsp_valid && rsp_id == 2'd2) n_rsp2 <= n_rsp2 + 1;
        if (gnt[2]) n_gnt2 <= n_gnt2 + 1;
        if (exp_bus.exp_start) n_start <= n_start + 1;
        if (exp_bus.exp_start && exp_bus.exp_done) n_bad_start <= n_bad_start + 1;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request in the current cycle and follow it to its response
    task automatic run_job(input string tag, input int id, input logic [31:0] x,
                           input logic [31:0] y_exp, input int lat_exp);
        int lat;
        req = '0;
        req[id] = 1'b1;
        req_x[id*WIDTH +: WIDTH] = x;
        @(negedge clk);
        chk({tag, "_gnt"}, 32'(gnt), 32'(1 << id));
        step();
        req = '0;
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) chk({tag, "_start"}, 32'(exp_bus.exp_start), 32'(lat_exp > 1));
            if (rsp_valid) begin
                lat = c;
                break;
            end
            step();
        end
        chk({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        chk({tag, "_id"}, 32'(rsp_id), 32'(id));
        chk({tag, "_y"}, rsp_y, y_exp);
        step();
        @(negedge clk);
        chk({tag, "_vdrop"}, 32'(rsp_valid), 32'd0);
        $display("job %s: id=%0d x=%h y=%h lat=%0d", tag, id, x, rsp_y, lat);
    endtask

    logic [31:0] rr_x [4] = '{32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 32'h0004_0000};
    logic [31:0] rr_y [4] = '{32'h0000_5E2D, 32'h0000_22A5, 32'h0000_0CBF, 32'h0000_04B0};

    initial begin
        int prev_cyc;
        int snap;
        int snap2;
        int snapg;
        int lat;

        // Reset state
        repeat (3) step();
        @(negedge clk);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_rsp_y", rsp_y, 32'd0);
        chk("rst_exp_x", exp_bus.exp_x, 32'd0);
        chk("rst_exp_start", 32'(exp_bus.exp_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_exp_reset", 32'(exp_bus.exp_reset), 32'd1);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_exp_reset_hold", 32'(exp_bus.exp_reset), 32'd1);
        step();
        @(negedge clk);
        chk("rel_exp_reset_drop", 32'(exp_bus.exp_reset), 32'd0);
        $display("reset: exp_reset=%0d busy=%0d", exp_bus.exp_reset, busy);

        // Single request, e^-1
        step();
        run_job("single", 0, 32'h0001_0000, 32'h0000_5E2D, 12);

        // Round-robin from rr_ptr=0 with all requests held
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        step();
        step();
        req = 4'b1111;
        for (int i = 0; i < 4; i++) req_x[i*WIDTH +: WIDTH] = rr_x[i];
        prev_cyc = 0;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (gnt != '0) break;
                step();
            end
            chk("rr_gnt", 32'(gnt), 32'(1 << (g % 4)));
            if (g > 0) chk("rr_spacing", 32'(cyc - prev_cyc), 32'd14);
            prev_cyc = cyc;
            step();
            if (g == 4) req = '0;
            lat = -1;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    lat = c;
                    break;
                end
                step();
            end
            chk("rr_rsp_seen", 32'(lat >= 0), 32'd1);
            chk("rr_rsp_id", 32'(rsp_id), 32'(g % 4));
            chk("rr_rsp_y", rsp_y, rr_y[g % 4]);
            $display("rr grant %0d: id=%0d y=%h", g, rsp_id, rsp_y);
            step();
        end

        // One response per job, start never overlaps done
        step();
        @(negedge clk);
        chk("rsp_count", 32'(n_rsp), 32'd6);
        chk("start_during_done", 32'(n_bad_start), 32'd0);
        $display("handshake: responses=%0d bad_starts=%0d", n_rsp, n_bad_start);

        // Reset during WAIT_DONE abandons the job (rr_ptr is 1 here)
        step();
        req = 4'b0010;
        req_x[1*WIDTH +: WIDTH] = 32'h0002_0000;
        @(negedge clk);
        chk("abort_gnt", 32'(gnt), 32'b0010);
        step();
        req = '0;
        repeat (4) step();
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd1);
        step();
        reset_n = 1'b0;
        step();
        @(negedge clk);
        chk("abort_exp_reset", 32'(exp_bus.exp_reset), 32'd1);
        chk("abort_busy0", 32'(busy), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_y", rsp_y, 32'd0);
        chk("abort_rsp_id", 32'(rsp_id), 32'd0);
        chk("abort_exp_x", exp_bus.exp_x, 32'd0);
        chk("abort_exp_start", 32'(exp_bus.exp_start), 32'd0);
        chk("abort_gnt0", 32'(gnt), 32'd0);
        snap = n_rsp;
        step();
        reset_n = 1'b1;
        repeat (15) step();
        @(negedge clk);
        chk("abort_no_rsp", 32'(n_rsp), 32'(snap));
        $display("abort: responses after reset=%0d", n_rsp - snap);
        step();
        run_job("post_reset", 3, 32'h0004_0000, 32'h0000_04B0, 12);

        // Short pulse on req[2] while busy is never serviced
        snap2 = n_rsp2;
        snapg = n_gnt2;
        step();
        req = 4'b0001;
        req_x[0 +: WIDTH] = 32'h0003_0000;
        @(negedge clk);
        chk("pulse_gnt0", 32'(gnt), 32'b0001);
        step();
        req = '0;
        step();
        step();
        req = 4'b0100;
        req_x[2*WIDTH +: WIDTH] = 32'h0001_0000;
        step();
        req = '0;
        lat = -1;
        for (int c = 4; c < 25; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                lat = c;
                break;
            end
            step();
        end
        chk("pulse_lat", 32'(lat), 32'd12);
        chk("pulse_rsp_id", 32'(rsp_id), 32'd0);
        chk("pulse_rsp_y", rsp_y, 32'h0000_0CBF);
        repeat (20) step();
        @(negedge clk);
        chk("pulse_no_gnt2", 32'(n_gnt2), 32'(snapg));
        chk("pulse_no_rsp2", 32'(n_rsp2), 32'(snap2));
        $display("pulse: gnt2=%0d rsp2=%0d", n_gnt2 - snapg, n_rsp2 - snap2);

`ifdef EXP_CLAMP_EN
        snap = n_start;
        step();
        run_job("clamp_hi", 1, 32'h000A_0000, 32'h0000_0000, 1);
        step();
        run_job("clamp_edge", 2, 32'h0008_0000, 32'h0000_0000, 1);
        step();
        run_job("clamp_neg", 3, 32'hFFFF_0000, 32'h0001_0000, 1);
        @(negedge clk);
        chk("clamp_no_start", 32'(n_start), 32'(snap));
        step();
        run_job("clamp_mid", 0, 32'h0002_0000, 32'h0000_22A5, 12);
        step();
        run_job("clamp_below", 1, 32'h0007_FFFF, 32'hDEAD_BEEF, 12);
`else
        step();
        run_job("pass_big", 1, 32'h000A_0000, 32'hDEAD_BEEF, 12);
        step();
        run_job("pass_neg", 2, 32'hFFFF_0000, 32'hDEAD_BEEF, 12);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/exp_share_ctrl.md
Name: exp_share_ctrl

Overview:
- Time-shares one e^(-x) exponential unit (Q16.16, start/done handshake) among N requesters in the Black-Scholes datapath, e.g. discount factor e^(-rT) and the normal-CDF exponent path.
- Arbitrates requests round-robin, latches the winner's operand, pulses the unit's start, captures its result and returns it with the requester ID.
- Owns the unit's reset so the controller and the unit can never disagree about state.

Parameters:
- WIDTH, 32, datapath width (Q16.16).
- N_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester-ID width; must equal ceil(log2(N_REQ)).
- X_MAX, 32'h00080000, clamp threshold 8.0 Q16.16 (used only with EXP_CLAMP_EN).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester request; held high until granted.
- req_x  in  N_REQ*WIDTH  packed operands; slice i is valid while req[i]=1.
- gnt  out  N_REQ  one-hot grant, combinational, one cycle; operand latched at that edge.
- rsp_valid  out  1  one-cycle result strobe.
- rsp_id  out  ID_W  requester index for rsp_y.
- rsp_y  out  WIDTH  e^(-x), Q16.16.
- busy  out  1  high in every state except IDLE.
- exp_reset  out  1  active-high reset to the unit; registered, equals ~reset_n delayed one cycle.
- exp_start  out  1  start pulse to the unit.
- exp_x  out  WIDTH  operand to the unit.
- exp_y  in  WIDTH  unit result.
- exp_done  in  1  unit done; high for exactly 2 cycles per computation.

Behaviour:
- Reset (reset_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_y=0, exp_x=0, exp_start=0, busy=0.
  - exp_reset=1 on the following cycle.
  - Reset mid-operation abandons the job; no response is ever issued for it.
- States:
  - IDLE: if any req, pick the first requester at or after rr_ptr (circular). Assert gnt[i], latch req_x[i] into exp_x, store id, set rr_ptr=(i+1) mod N_REQ, go to ISSUE. No req: stay.
  - ISSUE: exp_start=1 this cycle only (exp_start is 1 iff state==ISSUE). Next state is WAIT_DONE. exp_x is held until the next grant.
  - WAIT_DONE: on the first exp_done=1 cycle, register rsp_y<=exp_y, rsp_id<=id, rsp_valid<=1, go to WAIT_CLR.
  - WAIT_CLR: rsp_valid drops after one cycle. Stay until exp_done=0, then go to IDLE. This guarantees the second done cycle is ignored and the next start is a clean rising edge.
- Latency:
  - The unit raises done 10 cycles after the ISSUE cycle.
  - gnt in cycle C0 gives exp_start in C1, exp_done in C11-C12, and rsp_valid in C12.
  - Earliest next gnt is C14.
- A request dropped before grant is legal and is never serviced. req is sampled only in IDLE.
- Simultaneous requests: strict round-robin; no requester waits more than N_REQ-1 services.
- Data passes through unmodified. No arithmetic on x or y without the optional feature.

Optional Feature:
- Macro EXP_CLAMP_EN.
- When defined, the value latched in IDLE is classified at grant:
  - x >= X_MAX (signed): go to state BYPASS, skipping the unit; rsp_y=0, rsp_valid in C1.
  - x < 0: BYPASS with rsp_y=32'h00010000 (1.0), rsp_valid in C1.
  - BYPASS returns to IDLE next cycle.
  - Otherwise the normal path is taken.
- Undefined: no BYPASS state, all operands go to the unit, X_MAX is unused.

Decomposition:
- Shared package bscalc_pkg holds:
  - Q16.16 constants ONE=32'h00010000 and X_MAX_DEFAULT=32'h00080000.
  - Controller state encoding IDLE/ISSUE/WAIT_DONE/WAIT_CLR/BYPASS.
- One sub-module, rr_arbiter: parameterised N_REQ; inputs req and ptr; outputs one-hot gnt, encoded idx and any_req. Pure combinational; rr_ptr stays in the controller.

Test Plan:
- Single request, req[0]=1, x=32'h00010000: gnt[0] in C0, exp_start in C1, rsp_valid in C12 with rsp_id=0 and rsp_y within 2 LSB of 32'h00005E2D (e^-1≈0.3679).
- req=4'b1111 held, rr_ptr=0: grants in order 0,1,2,3,0, spaced 14 cycles apart; each rsp_id matches its grant.
- exp_done is held 2 cycles: exactly one rsp_valid per job; exp_start never goes high while exp_done=1.
- reset_n low during WAIT_DONE: next cycle exp_reset=1 and all outputs are 0; no rsp_valid; a fresh request after release completes normally.
- EXP_CLAMP_EN defined:
  - x=32'h000A0000: rsp_y=0 one cycle after gnt, exp_start never asserted.
  - x=32'hFFFF0000: rsp_y=32'h00010000.
  - x=32'h00020000: uses the unit, rsp_y≈32'h000022A5.
- req[2] pulses for 1 cycle while busy: never granted, no response for id 2.
